port_b_input_sampler: RTL and testbench
=======================================

Name: port_b_input_sampler

Overview:
- Input-direction counterpart to the Port B output driver: samples the eight RB pins and delivers the registered value onto the 8-bit internal data bus when PORTB is read.
- Provides PIC16F84 Port B interrupt sources: RB0/INT edge detection and RB7:RB4 interrupt-on-change mismatch detection.
- Sits between the external pins and the file-register read mux / INTCON flag logic.
- This block owns no interrupt flags. It only emits set requests.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per pin; legal range 2..3.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rb0..rb7  input  1 each  external Port B pin levels (asynchronous to clk)
trisb  input  8  TRISB register; 1 = pin is an input
intedg  input  1  OPTION.INTEDG; 1 = rising edge, 0 = falling edge
rd_en  input  1  one-cycle strobe: core reads PORTB this cycle
data_out  output  8  last PORTB read value, {rb7..rb0}
int_set  output  1  one-cycle request to set INTCON.INTF
rbif_set  output  1  one-cycle request to set INTCON.RBIF
rb_mismatch  output  1  level: RB7:RB4 currently differ from the last-read latch

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high. All flops are cleared on reset assertion, independent of clk.
- Reset values:
  - data_out = 8'h00; int_set = 0; rbif_set = 0; rb_mismatch = 0.
  - Synchronizer chains, rb_latch[7:4], rb0_prev and the warm-up counter are all 0.
- Synchronizer: each rbN passes through SYNC_STAGES flops. pin_s[7:0] is the final-stage vector. A pin change appears on pin_s exactly SYNC_STAGES clocks later.
- Warm-up:
  - After reset deasserts, a counter runs for SYNC_STAGES+1 clocks. warm = 1 when the counter saturates.
  - While warm = 0: int_set, rbif_set and rb_mismatch are forced to 0. rb_latch <= pin_s[7:4] and rb0_prev <= pin_s[0] every cycle.
  - Purpose: no spurious edge or mismatch is reported when pins are high at reset release.
- Read path:
  - On rd_en: data_out <= pin_s on the next edge (1-cycle latency), and rb_latch <= pin_s[7:4] on the same edge.
  - Without rd_en, data_out holds its value.
  - All 8 bits are read from the pins regardless of trisb; output pins read back their pin level.
- Interrupt-on-change:
  - mis_c = |((pin_s[7:4] ^ rb_latch) & trisb[7:4]).
  - rb_mismatch <= mis_c & warm & ~rd_en.
  - rbif_set <= 1 for exactly one cycle when rb_mismatch goes 0->1. It is not re-pulsed while the mismatch persists.
  - A read clears the mismatch: rb_mismatch goes to 0 on the rd_en edge. If pins still differ from the newly latched value on the following cycle, it re-evaluates (normally equal, so it stays 0).
  - Same-cycle pin change and rd_en: the read wins. The latch captures the current pin_s and no pulse is produced for that change.
  - trisb[k] = 0 masks bit k. Toggling trisb[k] from 0 to 1 while the pin differs from the latch produces a mismatch and a pulse.
- RB0/INT:
  - rb0_prev <= pin_s[0] every cycle.
  - rise = pin_s[0] & ~rb0_prev; fall = ~pin_s[0] & rb0_prev.
  - int_set <= warm & (intedg ? rise : fall), a one-cycle pulse.
  - Active regardless of trisb[0].
  - Changing intedg alone never produces int_set; only pin history matters.
- Reset mid-operation: all state is cleared asynchronously, and warm-up restarts after deassertion.
- Total latency from a pin edge to the int_set/rbif_set pulse: SYNC_STAGES + 1 clocks.

Decomposition:
- Shared package (pic16f84_pkg), reused by the INTCON and file-register blocks:
  - PORTB address constant 8'h06.
  - INTCON bit indices: INTF = 1, RBIF = 0.
  - OPTION bit index: INTEDG = 6.
- One natural sub-module, sync_cell: a SYNC_STAGES-deep single-bit synchronizer with asynchronous active-high reset, instantiated 8 times.

Test Plan:
- Reset release with rb = 8'hFF and trisb = 8'hFF:
  - int_set, rbif_set and rb_mismatch stay 0 for 20 cycles.
  - rd_en -> data_out = 8'hFF one cycle later.
- intedg = 1: rb0 goes 0->1 -> a single int_set pulse exactly SYNC_STAGES+1 clocks after the edge. rb0 going 1->0 -> no pulse. Repeat with intedg = 0 and expect the mirror behaviour.
- Latch = 4'h0; rb4 goes to 1:
  - rb_mismatch rises and rbif_set pulses once.
  - Holding 10 cycles -> no further pulse.
  - rd_en -> rb_mismatch = 0 next cycle; data_out[4] = 1.
- trisb = 8'h0F: toggle rb7 -> no mismatch and no rbif_set. Then set trisb = 8'hFF -> mismatch and a single pulse.
- pin_s[5] changes in the same cycle as rd_en -> latch takes the new value, no rbif_set, and rb_mismatch stays 0.
- Assert reset during an active mismatch -> all outputs are 0 immediately (asynchronous). After release, pins are held stable -> no pulses.

Source files
------------

// File: rtl/pic16f84_pkg.sv
// rtl/pic16f84_pkg.sv - shared PIC16F84 constants and helpers
package pic16f84_pkg;

  // File-register address of PORTB
  localparam logic [7:0] PORTB_ADDR = 8'h06;

  // INTCON bit indices
  localparam int INTCON_INTF = 1;
  localparam int INTCON_RBIF = 0;

  // OPTION bit index
  localparam int OPTION_INTEDG = 6;

  // RB0/INT edge qualifier: rising when sel_rise = 1, falling otherwise
  function automatic logic rb0_edge(input logic cur, input logic prev, input logic sel_rise);
    return sel_rise ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// rtl/sync_cell.sv - single-bit multi-flop synchronizer
module sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the asynchronous level through the flop chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/port_b_input_sampler.sv
// rtl/port_b_input_sampler.sv - Port B pin sampler with RB0/INT and RB7:RB4 change detection
module port_b_input_sampler
  import pic16f84_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rb0,
  input  logic       rb1,
  input  logic       rb2,
  input  logic       rb3,
  input  logic       rb4,
  input  logic       rb5,
  input  logic       rb6,
  input  logic       rb7,
  input  logic [7:0] trisb,
  input  logic       intedg,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       int_set,
  output logic       rbif_set,
  output logic       rb_mismatch
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [7:0] pin_raw;
  logic [7:0] pin_s;
  logic [3:0] rb_latch;
  logic       rb0_prev;
  logic [2:0] warm_cnt;
  logic       warm;
  logic       mis_c;
  logic       mis_now;

  assign pin_raw = {rb7, rb6, rb5, rb4, rb3, rb2, rb1, rb0};

  for (genvar i = 0; i < 8; i++) begin : g_sync
    sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pin_raw[i]),
      .q     (pin_s[i])
    );
  end

  assign warm    = (warm_cnt == WARM_MAX);
  assign mis_c   = |((pin_s[7:4] ^ rb_latch) & trisb[7:4]);
  // a read in the same cycle wins over any pending change
  assign mis_now = mis_c & warm & ~rd_en;

  // warm-up counter: lets the synchronizers fill before edges are trusted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      warm_cnt <= '0;
    else if (!warm) warm_cnt <= warm_cnt + 3'd1;
  end

  // read path, change latch, edge history and interrupt requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= 8'h00;
      rb_latch    <= 4'h0;
      rb0_prev    <= 1'b0;
      rb_mismatch <= 1'b0;
      rbif_set    <= 1'b0;
      int_set     <= 1'b0;
    end else begin
      if (rd_en) data_out <= pin_s;
      if (!warm || rd_en) rb_latch <= pin_s[7:4];
      rb0_prev    <= pin_s[0];
      rb_mismatch <= mis_now;
      rbif_set    <= mis_now & ~rb_mismatch;
      int_set     <= warm & rb0_edge(pin_s[0], rb0_prev, intedg);
    end
  end

endmodule

// File: tb/tb_port_b_input_sampler.sv
// tb/tb_port_b_input_sampler.sv - directed bench for port_b_input_sampler
module tb_port_b_input_sampler;

  logic       clk;
  logic       reset;
  logic [7:0] rb;
  logic [7:0] trisb;
  logic       intedg;
  logic       rd_en;
  logic [7:0] data_out;
  logic       int_set;
  logic       rbif_set;
  logic       rb_mismatch;

  int checks = 0;
  int errors = 0;

  port_b_input_sampler #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rb0         (rb[0]),
    .rb1         (rb[1]),
    .rb2         (rb[2]),
    .rb3         (rb[3]),
    .rb4         (rb[4]),
    .rb5         (rb[5]),
    .rb6         (rb[6]),
    .rb7         (rb[7]),
    .trisb       (trisb),
    .intedg      (intedg),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .int_set     (int_set),
    .rbif_set    (rbif_set),
    .rb_mismatch (rb_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic i_e, input logic r_e, input logic m_e);
    check({tag, ".int_set"}, {7'd0, int_set}, {7'd0, i_e});
    check({tag, ".rbif_set"}, {7'd0, rbif_set}, {7'd0, r_e});
    check({tag, ".rb_mismatch"}, {7'd0, rb_mismatch}, {7'd0, m_e});
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    rb     = 8'hFF;
    trisb  = 8'hFF;
    intedg = 1'b1;
    rd_en  = 1'b0;
    repeat (3) step();
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset.data_out", data_out, 8'h00);

    // release with all pins high: warm-up must hide the apparent edges
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_flags("warmup", 1'b0, 1'b0, 1'b0);
    end
    do_read();
    check("read_ff.data_out", data_out, 8'hFF);

    // intedg = 1: falling edge ignored, rising edge pulses after 3 clocks
    rb[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rise_mode_fall.int_set", {7'd0, int_set}, 8'h00);
    end
    rb[0] = 1'b1;
    step(); check("rise.c1", {7'd0, int_set}, 8'h00);
    step(); check("rise.c2", {7'd0, int_set}, 8'h00);
    step(); check("rise.c3", {7'd0, int_set}, 8'h01);
    step(); check("rise.c4", {7'd0, int_set}, 8'h00);
    rb[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rise_mode_fall2.int_set", {7'd0, int_set}, 8'h00);
    end

    // intedg = 0: flipping intedg alone is silent, then mirror behaviour
    intedg = 1'b0;
    step(); check("intedg_flip.int_set", {7'd0, int_set}, 8'h00);
    step(); check("intedg_flip2.int_set", {7'd0, int_set}, 8'h00);
    rb[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fall_mode_rise.int_set", {7'd0, int_set}, 8'h00);
    end
    rb[0] = 1'b0;
    step(); check("fall.c1", {7'd0, int_set}, 8'h00);
    step(); check("fall.c2", {7'd0, int_set}, 8'h00);
    step(); check("fall.c3", {7'd0, int_set}, 8'h01);
    step(); check("fall.c4", {7'd0, int_set}, 8'h00);

    // bring latch to 4'h0: pins drop, mismatch appears, read clears it
    rb = 8'h00;
    repeat (4) step();
    check("drop.rb_mismatch", {7'd0, rb_mismatch}, 8'h01);
    do_read();
    check("drop_read.rb_mismatch", {7'd0, rb_mismatch}, 8'h00);
    check("drop_read.data_out", data_out, 8'h00);

    // rb4 rises: one rbif pulse, mismatch held, no re-pulse
    rb[4] = 1'b1;
    step(); check_flags("rb4.c1", 1'b0, 1'b0, 1'b0);
    step(); check_flags("rb4.c2", 1'b0, 1'b0, 1'b0);
    step(); check_flags("rb4.c3", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_flags("rb4.hold", 1'b0, 1'b0, 1'b1);
    end
    do_read();
    check_flags("rb4.read", 1'b0, 1'b0, 1'b0);
    check("rb4.read.data_out", data_out, 8'h10);
    step(); check_flags("rb4.after", 1'b0, 1'b0, 1'b0);

    // masked bit: rb7 toggles with trisb[7] = 0, then unmasking reveals it
    trisb = 8'h0F;
    rb    = 8'h90;
    for (int i = 0; i < 5; i++) begin
      step();
      check_flags("masked", 1'b0, 1'b0, 1'b0);
    end
    trisb = 8'hFF;
    step(); check_flags("unmask.c1", 1'b0, 1'b1, 1'b1);
    step(); check_flags("unmask.c2", 1'b0, 1'b0, 1'b1);
    do_read();
    check_flags("unmask.read", 1'b0, 1'b0, 1'b0);
    check("unmask.read.data_out", data_out, 8'h90);

    // rb5 reaches pin_s in the very cycle rd_en is sampled: read wins
    rb[5] = 1'b1;
    step(); check_flags("same.c1", 1'b0, 1'b0, 1'b0);
    step(); check_flags("same.c2", 1'b0, 1'b0, 1'b0);
    do_read();
    check_flags("same.read", 1'b0, 1'b0, 1'b0);
    check("same.read.data_out", data_out, 8'hB0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_flags("same.after", 1'b0, 1'b0, 1'b0);
    end

    // reset lands asynchronously on an active mismatch
    rb = 8'h30;
    repeat (3) step();
    check("pre_reset.rb_mismatch", {7'd0, rb_mismatch}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check_flags("async_reset", 1'b0, 1'b0, 1'b0);
    check("async_reset.data_out", data_out, 8'h00);
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_flags("rewarm", 1'b0, 1'b0, 1'b0);
    end
    do_read();
    check("rewarm.data_out", data_out, 8'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
